// File: rtl/csa_resolver32.sv
// csa_resolver32: resolves a carry-save sum/carry pair to binary, SLICE_W bits per cycle.
// Optional signed-overflow flag is built only when CSA_RESOLVER_OVF_EN is defined.
module csa_resolver32 #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   carry_q;
    logic [IDX_W-1:0]   slice_idx;
    logic               slice_carry;
    logic [SLICE_W-1:0] res_sl   [NSLICE];
    logic [SLICE_W-1:0] sum_sl   [NSLICE];
    logic [SLICE_W-1:0] carry_sl [NSLICE];
    logic [SLICE_W-1:0] sum_cur;
    logic [SLICE_W-1:0] carry_cur;
    logic [SLICE_W:0]   slice_add;
    logic               accept;
    logic               last_slice;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        assign sum_sl[g]                       = sum_q[g*SLICE_W +: SLICE_W];
        assign carry_sl[g]                     = carry_q[g*SLICE_W +: SLICE_W];
        assign out_result[g*SLICE_W +: SLICE_W] = res_sl[g];
    end

    assign in_ready   = (state == IDLE) & rst_n;
    assign out_valid  = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign last_slice = (state == BUSY) && (slice_idx == LAST_IDX);

    // One SLICE_W-bit adder shared by every slice; the slice carry ripples through a register.
    assign sum_cur   = sum_sl[slice_idx];
    assign carry_cur = carry_sl[slice_idx];
    assign slice_add = {1'b0, sum_cur} + {1'b0, carry_cur} + {{SLICE_W{1'b0}}, slice_carry};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            slice_idx   <= '0;
            slice_carry <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            out_cout    <= 1'b0;
            for (int unsigned i = 0; i < NSLICE; i++) begin
                res_sl[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_q       <= in_sum;
                        carry_q     <= in_carry;
                        slice_carry <= in_cin;
                        slice_idx   <= '0;
                    end
                end
                BUSY: begin
                    res_sl[slice_idx] <= slice_add[SLICE_W-1:0];
                    slice_carry       <= slice_add[SLICE_W];
                    if (last_slice) begin
                        out_cout  <= slice_add[SLICE_W];
                        slice_idx <= '0;
                    end else begin
                        slice_idx <= slice_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_RESOLVER_OVF_EN
    logic ovf_q;
    logic top_cin;

    // Carry into the MSB recovered from the top slice's MSB operand and result bits.
    assign top_cin = sum_cur[SLICE_W-1] ^ carry_cur[SLICE_W-1] ^ slice_add[SLICE_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_slice) begin
            ovf_q <= top_cin ^ slice_add[SLICE_W];
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_resolver32.sv
// tb_csa_resolver32: directed and randomized checks of csa_resolver32 against an arithmetic model.
// Honours CSA_RESOLVER_OVF_EN for the expected overflow flag.
module tb_csa_resolver32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = '0;
    logic [31:0] in_carry = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_cout;
    logic        out_ovf;

    int n_cmp = 0;
    int n_mis = 0;
    int n_got = 0;
    logic [33:0] exp_q[$];

`ifdef CSA_RESOLVER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    csa_resolver32 #(.WIDTH(32), .SLICE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, result} from exact unsigned and signed arithmetic.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [63:0] u;
        longint      s;
        logic        ovf;
        u   = 64'(a) + 64'(b) + 64'(ci);
        s   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        ovf = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(32'h8000_0000));
        if (!OVF_ON) ovf = 1'b0;
        return {ovf, u[32], u[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic [31:0] er, input logic ec, input logic eo, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, in_ready, 64'd1);
        in_sum = a; in_carry = b; in_cin = ci; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 64'd4);
        check({tag, "_result"}, out_result, er);
        check({tag, "_cout"}, out_cout, ec);
        check({tag, "_ovf"}, out_ovf, eo);
        check({tag, "_busy_ready"}, in_ready, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_sum = ~a; in_carry = 32'h1; in_cin = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, "_hold_result"}, {out_valid, out_cout, out_ovf, out_result}, {1'b1, ec, eo, er});
            check({tag, "_hold_ready"}, in_ready, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_hs_valid"}, out_valid, 64'd0);
        check({tag, "_hs_ready"}, in_ready, 64'd1);
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_no_extra"}, out_valid, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        acc;
        int          guard;
        logic [33:0] e;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_outputs", {out_valid, out_cout, out_ovf, out_result}, 64'd0);
            check("rst_ready", in_ready, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 0);
        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON, 0);
        run_op("bp",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 10);

        // Reset during the second BUSY cycle.
        @(negedge clk);
        in_sum = 32'h1234_5678; in_carry = 32'h1111_1111; in_cin = 1'b0; in_valid = 1'b1;
        check("midrst_ready", in_ready, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outputs", {out_valid, out_cout, out_ovf, out_result}, 64'd0);
        check("midrst_ready_low", in_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_valid", out_valid, 64'd0);
        end
        run_op("post_rst", 32'hA000_0000, 32'h6000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);

        fork
            begin : drv
                for (int i = 0; i < 100; i++) begin
                    a = $urandom;
                    b = ($urandom_range(0, 4) == 0) ? ~a : 32'($urandom);
                    c = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    while ($urandom_range(0, 3) == 0) @(negedge clk);
                    in_sum = a; in_carry = b; in_cin = c; in_valid = 1'b1;
                    guard = 0;
                    do begin
                        acc = in_ready;
                        @(posedge clk);
                        if (!acc) begin
                            guard++;
                            @(negedge clk);
                        end
                    end while (!acc && guard < 200);
                    if (!acc) check("drv_timeout", acc, 64'd1);
                    exp_q.push_back(ref_model(a, b, c));
                    #1;
                    in_valid = 1'b0;
                end
            end
            begin : mon
                int cyc;
                cyc = 0;
                while (n_got < 100 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("stream_extra", 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("stream_result", out_result, e[31:0]);
                            check("stream_cout", out_cout, e[32]);
                            check("stream_ovf", out_ovf, e[33]);
                        end
                        n_got++;
                    end
                end
                check("stream_count", n_got, 64'd100);
            end
        join

        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("stream_drain_valid", out_valid, 64'd0);
        check("stream_queue_empty", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
